// File: rtl/stage_sequencer_if.sv
// Control/strobe bundle between the LEGv8 stage sequencer and the datapath stages.
// The sequencer takes the master modport; the datapath side takes the slave modport.
interface stage_sequencer_if;
  logic        start;
  logic        hold;
  logic [10:0] opcode;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        fetch_en;
  logic        read_strobe;
  logic        exec_en;
  logic        mem_strobe;
  logic        write_strobe;
  logic        pc_update;
  logic        busy;
  logic        halted;
  logic [2:0]  state;
  logic [31:0] instr_count;
  logic [31:0] cycle_count;

  modport master (
    input  start, hold, opcode, mem_read, mem_write, reg_write,
    output fetch_en, read_strobe, exec_en, mem_strobe, write_strobe, pc_update,
    output busy, halted, state, instr_count, cycle_count
  );

  modport slave (
    output start, hold, opcode, mem_read, mem_write, reg_write,
    input  fetch_en, read_strobe, exec_en, mem_strobe, write_strobe, pc_update,
    input  busy, halted, state, instr_count, cycle_count
  );
endinterface

// File: rtl/stage_sequencer.sv
// Multi-cycle LEGv8 stage sequencer: FETCH/DECODE/EXEC/[MEM]/[WB] with hold and halt.
// Define PERF_COUNT_EN to build the retired-instruction and busy-cycle counters.
module stage_sequencer (
  input  logic               clk,
  input  logic               rst_n,
  stage_sequencer_if.master  bus
);

  localparam int unsigned OP_W  = 11;
  localparam int unsigned CNT_W = 32;
  localparam logic [OP_W-1:0] HALT_OPCODE = 11'h7FF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;

  state_t state_q;
  logic   mem_read_q;
  logic   mem_write_q;
  logic   reg_write_q;

  logic   last_stage;
  logic   pc_update;
  logic   busy;

  // State register and decoded-control flags; hold freezes both, illegal codes recover to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      reg_write_q <= 1'b0;
    end else if (!bus.hold) begin
      case (state_q)
        IDLE:    if (bus.start) state_q <= FETCH;
        FETCH:   state_q <= DECODE;
        DECODE: begin
          mem_read_q  <= bus.mem_read;
          mem_write_q <= bus.mem_write;
          reg_write_q <= bus.reg_write;
          state_q     <= (bus.opcode == HALT_OPCODE) ? HALT : EXEC;
        end
        EXEC: begin
          if (mem_read_q || mem_write_q) state_q <= MEM;
          else if (reg_write_q)          state_q <= WB;
          else                           state_q <= FETCH;
        end
        MEM:     state_q <= reg_write_q ? WB : FETCH;
        WB:      state_q <= FETCH;
        HALT:    if (bus.start) state_q <= FETCH;
        default: state_q <= IDLE;
      endcase
    end else if (state_q == state_t'(3'd7)) begin
      state_q <= IDLE;
    end
  end

  // Final stage of the current instruction, from the latched control flags.
  assign last_stage = (state_q == WB)
                   || (state_q == MEM  && !reg_write_q)
                   || (state_q == EXEC && !mem_read_q && !mem_write_q && !reg_write_q);

  assign pc_update = last_stage && !bus.hold;
  assign busy      = (state_q != IDLE) && (state_q != HALT);

  assign bus.fetch_en     = (state_q == FETCH)  && !bus.hold;
  assign bus.read_strobe  = (state_q == DECODE) && !bus.hold;
  assign bus.exec_en      = (state_q == EXEC)   && !bus.hold;
  assign bus.mem_strobe   = (state_q == MEM)    && !bus.hold;
  assign bus.write_strobe = (state_q == WB)     && !bus.hold;
  assign bus.pc_update    = pc_update;
  assign bus.busy         = busy;
  assign bus.halted       = (state_q == HALT);
  assign bus.state        = 3'(state_q);

`ifdef PERF_COUNT_EN
  logic [CNT_W-1:0] instr_count_q;
  logic [CNT_W-1:0] cycle_count_q;

  // Free-running wrap-around performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_count_q <= '0;
      cycle_count_q <= '0;
    end else begin
      if (pc_update) instr_count_q <= instr_count_q + CNT_W'(1);
      if (busy)      cycle_count_q <= cycle_count_q + CNT_W'(1);
    end
  end

  assign bus.instr_count = instr_count_q;
  assign bus.cycle_count = cycle_count_q;
`else
  assign bus.instr_count = CNT_W'(0);
  assign bus.cycle_count = CNT_W'(0);
`endif

endmodule
